fwft_ram_ctrl: RTL and testbench

FWFT_RAM_CTRL -- requirements
Module: fwft_ram_ctrl

---
 rtl/fwft_ram_ctrl_if.sv | 26 ++
 rtl/fwft_ram_ctrl.sv | 92 +++++++++
 tb/tb_fwft_ram_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fwft_ram_ctrl_if.sv
// Push/pop bus of the first-word-fall-through FIFO controller.
// The producer/consumer side takes the master modport; the controller takes the slave modport.
interface fwft_ram_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic                  wr_req_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  full_o;
    logic                  rd_req_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  empty_o;
    logic [ADDR_WIDTH:0]   usedw_o;
    logic                  ovf_o;
    logic                  unf_o;

    modport master (
        output wr_req_i, wr_data_i, rd_req_i,
        input  full_o, rd_data_o, empty_o, usedw_o, ovf_o, unf_o
    );

    modport slave (
        input  wr_req_i, wr_data_i, rd_req_i,
        output full_o, rd_data_o, empty_o, usedw_o, ovf_o, unf_o
    );
endinterface

// File: rtl/fwft_ram_ctrl.sv
// FWFT FIFO controller around an external dual-port RAM with a registered read port.
// The RAM output register doubles as the head register, so no extra data storage lives here.
module fwft_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fwft_ram_ctrl_if.slave        bus,
    output logic                  ram_wr_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic                  ram_rd_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      ram_cnt;
    logic [CNT_W-1:0]      usedw;
    logic                  head_vld;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic ram_rd;

    function automatic logic [CNT_W-1:0] net_count(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            res = cnt - CNT_W'(1);
        end
        return res;
    endfunction

    // Flags come from registers only; inputs reach nothing but the strobes.
    assign full   = (usedw == DEPTH);
    assign empty  = ~head_vld;
    assign push   = bus.wr_req_i & ~full;
    assign pop    = bus.rd_req_i & head_vld;
    // Refill the head whenever it is vacant or leaving; ram_cnt is registered,
    // so a word written this cycle can never be read in the same cycle.
    assign ram_rd = (ram_cnt != '0) & (~head_vld | pop);

    assign bus.full_o    = full;
    assign bus.empty_o   = empty;
    assign bus.usedw_o   = usedw;
    assign bus.rd_data_o = ram_rd_data_i;
    assign bus.ovf_o     = bus.wr_req_i & full;
    assign bus.unf_o     = bus.rd_req_i & empty;

    assign ram_wr_o      = push;
    assign ram_wr_addr_o = wr_ptr;
    assign ram_wr_data_o = bus.wr_data_i;
    assign ram_rd_o      = ram_rd;
    assign ram_rd_addr_o = rd_ptr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            usedw    <= '0;
            head_vld <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            ram_cnt <= net_count(ram_cnt, push, ram_rd);
            usedw   <= net_count(usedw, push, pop);
            if (ram_rd) begin
                head_vld <= 1'b1;
            end else if (pop) begin
                head_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fwft_ram_ctrl.sv
// Randomized scoreboard bench for fwft_ram_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_fwft_ram_ctrl;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int D  = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fwft_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic          ram_wr;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_rd;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    fwft_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus.slave),
        .ram_wr_o      (ram_wr),
        .ram_wr_addr_o (ram_wr_addr),
        .ram_wr_data_o (ram_wr_data),
        .ram_rd_o      (ram_rd),
        .ram_rd_addr_o (ram_rd_addr),
        .ram_rd_data_i (ram_rd_data)
    );

    // Dual-port RAM: registered read, output held while read enable is low.
    logic [DW-1:0] mem [D];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd) ram_rd_data <= mem[ram_rd_addr];
    end

    typedef struct {
        logic          vld;
        logic          empty;
        logic          full;
        logic [AW:0]   usedw;
        logic          ovf;
        logic          unf;
    } exp_t;

    typedef struct {
        logic [DW-1:0] d;
        int            pc;
    } word_t;

    exp_t          flag_q[$];
    logic [DW-1:0] data_q[$];
    word_t         mq[$];

    int            cyc = 0;
    int            last_pop = -10;
    logic          known = 1'b0;
    logic          p_wr = 1'b0;
    logic          p_rd = 1'b0;
    logic          p_rst = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          p_empty = 1'b1;
    logic          p_full = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus; the model advances by the previous cycle's inputs first.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic r);
        exp_t e;
        int   vis;
        @(posedge clk);
        if (p_rst) begin
            mq.delete();
            data_q.delete();
            last_pop = -10;
            known = 1'b1;
        end else begin
            if (p_rd && !p_empty) begin
                mq.delete(0);
                last_pop = cyc;
            end
            if (p_wr && !p_full) begin
                mq.push_back('{p_data, cyc});
                data_q.push_back(p_data);
            end
        end
        cyc++;
        #1;
        bus.wr_req_i  = wr;
        bus.wr_data_i = d;
        bus.rd_req_i  = rd;
        rst           = r;
        // A word is visible two cycles after its push, and no earlier than
        // one cycle after the word ahead of it was popped.
        vis = 0;
        if (mq.size() > 0) vis = (mq[0].pc + 2 > last_pop + 1) ? mq[0].pc + 2 : last_pop + 1;
        e.vld   = known;
        e.usedw = (AW+1)'(mq.size());
        e.full  = (mq.size() == D);
        e.empty = !(mq.size() > 0 && cyc >= vis);
        e.ovf   = wr & e.full;
        e.unf   = rd & e.empty;
        flag_q.push_back(e);
        p_wr = wr; p_rd = rd; p_rst = r; p_data = d; p_empty = e.empty; p_full = e.full;
    endtask

    // Monitor: consumes one expectation per cycle and one data word per observed pop.
    exp_t me;
    always @(negedge clk) begin
        if (flag_q.size() > 0) begin
            me = flag_q.pop_front();
            if (me.vld) begin
                chk("empty_o", 32'(bus.empty_o), 32'(me.empty));
                chk("full_o",  32'(bus.full_o),  32'(me.full));
                chk("usedw_o", 32'(bus.usedw_o), 32'(me.usedw));
                chk("ovf_o",   32'(bus.ovf_o),   32'(me.ovf));
                chk("unf_o",   32'(bus.unf_o),   32'(me.unf));
                if (bus.rd_req_i === 1'b1 && bus.empty_o === 1'b0) begin
                    if (data_q.size() == 0) begin
                        chk("pop_with_no_word", 32'(1), 32'(0));
                    end else begin
                        chk("rd_data_o", 32'(bus.rd_data_o), 32'(data_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.wr_req_i  = 1'b0;
        bus.wr_data_i = '0;
        bus.rd_req_i  = 1'b0;
        rst           = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);

        // Single word latency, then pop it.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);

        // Fill to full, overflow, full with simultaneous push and pop, drain past empty.
        for (int i = 0; i < D; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < D + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);

        // Four resident words, then push and pop every cycle.
        for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);

        // Push/pop pairs from empty across the address wrap.
        for (int i = 0; i < 40; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with shifting push/pop bias.
        for (int blk = 0; blk < 6; blk++) begin
            int wp;
            int rp;
            wp = (blk % 2 == 0) ? 80 : 35;
            rp = (blk % 2 == 0) ? 35 : 80;
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(99) < wp), DW'($urandom), ($urandom_range(99) < rp), 1'b0);
            end
        end

        // Reset mid-operation with ten words stored, then one fresh word.
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
        repeat (40) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, DW'(8'h50 + i), 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b1);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(flag_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
